nes_pad_reader: RTL and testbench
=================================

Name: nes_pad_reader

Overview:
- Console-side reader for a standard NES-style gamepad (4021 shift register inside the pad) feeding paddle control into the pong core.
- On a poll strobe, typically once per frame from the video timing's vsync, it pulses latch, clocks out 8 serial bits, and presents a registered, active-high button byte with a one-cycle valid pulse.
- The pad drives data; this block drives latch and clock.

Parameters:
- HALF, 150, system clocks per half pad-clock period (6 us at 25 MHz). Minimum 4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle poll request; ignored while busy=1
- pad_data  input  1  serial data from pad, active-low (0 = pressed), asynchronous to clk
- pad_latch  output  1  latch/strobe to pad, active-high
- pad_clk  output  1  shift clock to pad; pad shifts on its rising edge
- buttons  output  8  last completed read, active-high: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right
- valid  output  1  one-cycle pulse when buttons updates
- busy  output  1  high from the cycle after start is accepted through the DONE cycle

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; pad_latch=0, pad_clk=0, valid=0, busy=0, buttons=8'h00.
  - Shift register, bit index, phase counter and synchronizer flops all cleared.
- Reset mid-transaction: aborts immediately, same values as above. No partial result is ever published.
- pad_data passes through a 2-flop synchronizer; every sample uses the synchronizer output. HALF>=4 guarantees a settled value.
- Phase counter counts 0..N-1 within each state; the phase ends on the cycle the counter equals N-1.
- IDLE:
  - latch=0, clk=0, busy=0.
  - start=1 -> LATCH, counter=0.
- LATCH:
  - pad_latch=1, pad_clk=0, busy=1, for 2*HALF cycles.
  - Then -> LOW with idx=0.
- LOW:
  - pad_latch=0, pad_clk=0 for HALF cycles.
  - On the last cycle, shift[idx] <= ~sync_data.
  - If idx==7 -> DONE, else -> HIGH.
- HIGH:
  - pad_clk=1 for HALF cycles.
  - Then idx <= idx+1 -> LOW.
- DONE (one cycle):
  - buttons <= shift, visible on the same cycle valid=1; busy=1.
  - -> IDLE.
- Cycle accounting (cycle 0 = edge where start is sampled):
  - pad_latch high cycles 1..2H.
  - pad_clk rises 7 times: first rise at cycle 3H+1, period 2H.
  - valid high exactly at cycle 17H+1. busy falls at cycle 17H+2.
- Other rules:
  - start while busy=1: ignored, no queueing.
  - start on the DONE cycle: ignored.
  - start on the first IDLE cycle: accepted.
  - buttons holds its value between reads; valid is never high two consecutive cycles.
  - Disconnected pad (pull-up, pad_data stuck 1) reads buttons=8'h00. Stuck 0 reads 8'hFF. No error flag.
  - idx is 3 bits; it never wraps because the transition is to DONE at idx==7.
  - Outputs pad_latch, pad_clk, valid, busy are registered, glitch-free from flops.

Test Plan:
- HALF=4, pad model shifting 8'b1111_1110 (A pressed, active-low) on pad_clk rising edges; start at cycle 0 -> pad_latch high cycles 1-8; 7 pad_clk pulses; valid at cycle 69 with buttons=8'h01; busy low at cycle 70.
- Pad pattern Up+Left+Start (active-low 8'b1010_0111) -> buttons=8'h58. Repeat read with no buttons -> buttons=8'h00 and a second valid pulse.
- pad_data held 1 (unplugged) -> buttons=8'h00. pad_data held 0 -> buttons=8'hFF.
- start pulsed at cycles 0, 10 and 69 -> exactly one transaction and one valid at 69. Start at cycle 70 -> second valid at cycle 139.
- rst asserted at cycle 30 mid-read with prior buttons=8'h01 -> next cycle pad_latch=0, pad_clk=0, busy=0, buttons=8'h00, no valid. Subsequent start runs a full clean read.
- pad_data toggling asynchronously between samples but stable within ±1 cycle of each sample point -> result matches stable values, no X on outputs.

Source files
------------

// File: rtl/nes_pad_reader.sv
// NES-style gamepad reader: on a poll strobe it latches the pad's 4021, clocks out
// eight serial bits and publishes an active-high button byte with a one-cycle valid pulse.
module nes_pad_reader #(
  parameter int HALF = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  // Handshake: start is a one-cycle request accepted only in IDLE (dropped otherwise,
  // never queued); busy is high from the cycle after acceptance through DONE; valid
  // pulses for exactly one cycle, in DONE, with buttons already holding the new byte.

  localparam int CW = $clog2(2 * HALF);
  localparam logic [CW-1:0] LAST_LATCH = CW'(2 * HALF - 1);
  localparam logic [CW-1:0] LAST_HALF  = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      idx, idx_next;
  logic [7:0]      shift, shift_next;
  logic            sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pad_data;
      sync2 <= sync1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    idx_next   = idx;
    shift_next = shift;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (start) state_next = LATCH;
      end
      LATCH: begin
        if (cnt == LAST_LATCH) begin
          state_next = LOW;
          cnt_next   = '0;
          idx_next   = 3'd0;
        end
      end
      LOW: begin
        // Sample at the end of the low phase, long after the pad's last shift settled.
        if (cnt == LAST_HALF) begin
          cnt_next        = '0;
          shift_next[idx] = ~sync2;
          state_next      = (idx == 3'd7) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (cnt == LAST_HALF) begin
          cnt_next   = '0;
          idx_next   = idx + 3'd1;
          state_next = LOW;
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      buttons   <= 8'h00;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shift     <= shift_next;
      pad_latch <= (state_next == LATCH);
      pad_clk   <= (state_next == HIGH);
      valid     <= (state_next == DONE);
      busy      <= (state_next != IDLE);
      if (state_next == DONE) buttons <= shift_next;
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader with HALF=4: a 4021-like pad model, directed reads and a
// scoreboard monitor that checks every valid pulse against queued expectations.
module tb_nes_pad_reader;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  nes_pad_reader #(.HALF(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons  (buttons),
    .valid    (valid),
    .busy     (busy)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- pad model ----------------
  logic [7:0] pad_pat  = 8'hFF;
  logic [7:0] pad_sr   = 8'hFF;
  logic       pclk_d   = 1'b0;
  logic       stuck_en = 1'b0;
  logic       stuck_val = 1'b1;
  logic       noise_en = 1'b0;
  logic       noise    = 1'b0;

  always @(posedge clk) begin
    if (pad_latch) pad_sr <= pad_pat;
    else if (pad_clk && !pclk_d) pad_sr <= {1'b1, pad_sr[7:1]};
    pclk_d <= pad_clk;
  end

  initial forever begin
    #7 noise = 1'($urandom_range(0, 1));
  end

  assign pad_data = stuck_en ? stuck_val : ((noise_en && pad_clk) ? noise : pad_sr[0]);

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         exp_t_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [7:0] e;
    int         t;
    if (valid === 1'b1) begin
      check("valid_single_cycle", 32'(prev_valid), 32'd0);
      check("buttons_known", 32'($isunknown(buttons)), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got buttons %0h with no read outstanding", buttons);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("buttons", 32'(buttons), 32'(e));
        check("valid_cycle", 32'(edge_n), 32'(t));
      end
    end
    prev_valid = valid;
  end

  // ---------------- driver tasks ----------------
  // Drives start on a falling edge; s is the rising edge that samples it (cycle 0).
  task automatic issue(input logic [7:0] pat, input logic [7:0] exp, input bit expect_it,
                       output int s);
    @(negedge clk);
    pad_pat = pat;
    start   = 1'b1;
    s       = edge_n + 1;
    if (expect_it) begin
      exp_q.push_back(exp);
      exp_t_q.push_back(s + 17 * H);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_edge(input int e);
    int n = 0;
    while (edge_n != e && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      $display("FAIL wait_edge_timeout: edge %0d never reached", e);
    end
  endtask

  task automatic pulse_at(input int e, input bit expect_it, input logic [7:0] exp);
    wait_edge(e - 1);
    start = 1'b1;
    if (expect_it) begin
      exp_q.push_back(exp);
      exp_t_q.push_back(e + 17 * H);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      $display("FAIL idle_timeout: busy stuck at %0b", busy);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int lat_cnt, lat_first, lat_last, rises, first_rise;
    logic pc_prev, busy1, busy69, busy70;

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pad_latch", 32'(pad_latch), 32'd0);
    check("rst_pad_clk",   32'(pad_clk),   32'd0);
    check("rst_valid",     32'(valid),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_buttons",   32'(buttons),   32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Read with A pressed, plus detailed latch / clock timing.
    issue(8'b1111_1110, 8'h01, 1'b1, s);
    lat_cnt = 0; lat_first = 0; lat_last = 0; rises = 0; first_rise = 0;
    pc_prev = 1'b0; busy1 = 1'b0; busy69 = 1'b0; busy70 = 1'b1;
    for (int r = 1; r <= 70; r++) begin
      if (r > 1) @(negedge clk);
      if (pad_latch === 1'b1) begin
        lat_cnt++;
        if (lat_first == 0) lat_first = r;
        lat_last = r;
      end
      if (pad_clk === 1'b1 && pc_prev === 1'b0) begin
        rises++;
        if (first_rise == 0) first_rise = r;
      end
      pc_prev = pad_clk;
      if (r == 1)  busy1  = busy;
      if (r == 69) busy69 = busy;
      if (r == 70) busy70 = busy;
    end
    check("latch_first_cycle", 32'(lat_first), 32'd1);
    check("latch_last_cycle",  32'(lat_last),  32'(2 * H));
    check("latch_cycles",      32'(lat_cnt),   32'(2 * H));
    check("pad_clk_rises",     32'(rises),     32'd7);
    check("first_rise_cycle",  32'(first_rise), 32'(3 * H + 1));
    check("busy_cycle1",       32'(busy1),     32'd1);
    check("busy_done_cycle",   32'(busy69),    32'd1);
    check("busy_after_done",   32'(busy70),    32'd0);
    wait_idle();
    check("buttons_hold", 32'(buttons), 32'h01);

    // Up+Left+Start, then nothing pressed.
    issue(8'b1010_0111, 8'h58, 1'b1, s);
    wait_idle();
    issue(8'b1111_1111, 8'h00, 1'b1, s);
    wait_idle();

    // Stuck pad lines.
    stuck_en = 1'b1; stuck_val = 1'b0;
    issue(8'hFF, 8'hFF, 1'b1, s);
    wait_idle();
    stuck_val = 1'b1;
    issue(8'h00, 8'h00, 1'b1, s);
    wait_idle();
    stuck_en = 1'b0;

    // Start while busy and on the DONE cycle is dropped; first IDLE cycle is accepted.
    issue(~8'h3C, 8'h3C, 1'b1, s);
    pulse_at(s + 10, 1'b0, 8'h00);
    pulse_at(s + 17 * H + 1, 1'b0, 8'h00);
    pulse_at(s + 17 * H + 2, 1'b1, 8'h3C);
    @(negedge clk);
    wait_idle();

    // Reset in the middle of a read.
    issue(8'b1111_1110, 8'h01, 1'b1, s);
    wait_idle();
    check("pre_reset_buttons", 32'(buttons), 32'h01);
    issue(8'b0000_0000, 8'hFF, 1'b0, s);
    wait_edge(s + 29);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pad_latch", 32'(pad_latch), 32'd0);
    check("midrst_pad_clk",   32'(pad_clk),   32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_valid",     32'(valid),     32'd0);
    check("midrst_buttons",   32'(buttons),   32'h00);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    issue(~8'h81, 8'h81, 1'b1, s);
    wait_idle();

    // Data line toggling while pad_clk is high, settled at every sample point.
    noise_en = 1'b1;
    issue(~8'h96, 8'h96, 1'b1, s);
    wait_idle();
    noise_en = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
